// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - carry-pipelined WIDTH-bit adder, one CHUNK-bit slice per stage
// Optional signed-overflow output guarded by PIPE_ADDER_OVF_EN.
module pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = WIDTH / CHUNK;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("pipelined_adder: WIDTH must be a multiple of CHUNK");
  end

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
`ifdef PIPE_ADDER_OVF_EN
  logic ovf_q, ovf_d;
`endif

  // What each stage sees from its upstream neighbour (the input port for stage 0).
  logic [STAGES-1:0] up_v, up_c;
  logic [WIDTH-1:0]  up_a [STAGES];
  logic [WIDTH-1:0]  up_b [STAGES];
  logic [WIDTH-1:0]  up_s [STAGES];
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] mask;
  logic [CHUNK:0]    slice;

  for (genvar k = 0; k < STAGES; k++) begin : g_up
    if (k == 0) begin : g_first
      assign up_v[k] = in_valid;
      assign up_c[k] = cin;
      assign up_a[k] = a;
      assign up_b[k] = b;
      assign up_s[k] = '0;
    end else begin : g_next
      assign up_v[k] = v_q[k-1];
      assign up_c[k] = c_q[k-1];
      assign up_a[k] = a_q[k-1];
      assign up_b[k] = b_q[k-1];
      assign up_s[k] = s_q[k-1];
    end
  end

  // Stage k can load unless it and every stage after it are full and the sink stalls.
  always_comb begin
    rdy  = '0;
    mask = '0;
    for (int k = 0; k < STAGES; k++) begin
      mask   = {STAGES{1'b1}} << k;
      rdy[k] = out_ready | ~(&(v_q | ~mask));
    end
  end

  assign in_ready = rdy[0];

  always_comb begin
    v_d   = v_q;
    c_d   = c_q;
    slice = '0;
`ifdef PIPE_ADDER_OVF_EN
    ovf_d = ovf_q;
`endif
    for (int k = 0; k < STAGES; k++) begin
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      s_d[k] = s_q[k];
    end
    for (int k = 0; k < STAGES; k++) begin
      if (rdy[k]) begin
        v_d[k] = up_v[k];
        if (up_v[k]) begin
          slice = {1'b0, up_a[k][k*CHUNK +: CHUNK]} + {1'b0, up_b[k][k*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, up_c[k]};
          a_d[k] = up_a[k];
          b_d[k] = up_b[k];
          s_d[k] = up_s[k];
          s_d[k][k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
          c_d[k] = slice[CHUNK];
`ifdef PIPE_ADDER_OVF_EN
          // Carry into the MSB is recovered as a^b^sum at that bit.
          if (k == STAGES - 1) begin
            ovf_d = up_a[k][WIDTH-1] ^ up_b[k][WIDTH-1] ^ slice[CHUNK-1] ^ slice[CHUNK];
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
`ifdef PIPE_ADDER_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      v_q <= v_d;
      c_q <= c_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
`ifdef PIPE_ADDER_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
`ifdef PIPE_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - bench for pipelined_adder against a queue-based reference model
// Covers the optional ovf output when PIPE_ADDER_OVF_EN is defined.
module tb_pipelined_adder;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int STAGES = WIDTH / CHUNK;
  localparam int N_RANDOM = 10000;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf_v;
`ifdef PIPE_ADDER_OVF_EN
  localparam bit HAS_OVF = 1'b1;
  logic ovf;
  assign ovf_v = ovf;
`else
  localparam bit HAS_OVF = 1'b0;
  assign ovf_v = 1'b0;
`endif

  pipelined_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PIPE_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;
  logic [WIDTH+1:0] exp_q [$];
  logic [WIDTH+1:0] prev_val;
  logic             prev_stall = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference result {ovf, cout, sum}: plain unsigned and signed arithmetic.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                            input logic c);
    logic [WIDTH:0] full;
    longint sres;
    logic o;
    full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    sres = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
    o = (sres > 32767) || (sres < -32768);
    return {HAS_OVF ? o : 1'b0, full};
  endfunction

  logic [WIDTH+1:0] dut_val;
  assign dut_val = {ovf_v, cout, sum};

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", in_ready, out_ready | (exp_q.size() < STAGES));
      if (exp_q.size() == 0) chk("spurious_out_valid", out_valid, 1'b0);
      else if (out_valid) chk("result", dut_val, exp_q[0]);
      if (prev_stall) chk("stall_hold", dut_val, prev_val);
      prev_stall = out_valid & ~out_ready;
      prev_val   = dut_val;
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        n_out++;
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
    in_valid = 1'b1;
    a = x;
    b = y;
    cin = c;
  endtask

  function automatic logic [WIDTH-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return '1;
      1: return 16'h8000;
      2: return '0;
      3: return 16'h7FFF;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  int acc;
  int base;
  int cycles;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_sum_cout", {cout, sum}, 17'h0);

    // Full ripple: accepted in the cycle after edge N, visible after edge N+4.
    drive(16'hFFFF, 16'h0001, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("ripple_not_early", out_valid, 1'b0);
    tick();
    chk("ripple_valid", out_valid, 1'b1);
    chk("ripple_sum_cout", {cout, sum}, 17'h1_0000);
    tick();

    // Back-to-back ops.
    drive(16'h1234, 16'h1111, 1'b0);
    tick();
    drive(16'h8000, 16'h8000, 1'b0);
    tick();
    drive(16'h00FF, 16'h0001, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    chk("b2b_op0", {out_valid, cout, sum}, 18'h2_2345);
    tick();
    chk("b2b_op1", {out_valid, cout, sum}, 18'h3_0000);
    tick();
    chk("b2b_op2", {out_valid, cout, sum}, 18'h2_0101);
    tick();
    chk("b2b_drained", out_valid, 1'b0);

    // Backpressure: fill to capacity, hold, then drain in order.
    out_ready = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      drive(16'h1000 * 16'(i + 1), 16'h0F0F, i[0]);
      tick();
    end
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_out_valid", out_valid, 1'b1);
    drive(16'hDEAD, 16'hBEEF, 1'b1);
    repeat (3) tick();
    chk("full_still_blocked", in_ready, 1'b0);
    in_valid = 1'b0;
    base = n_out;
    out_ready = 1'b1;
    repeat (STAGES) tick();
    chk("drain_count", n_out - base, STAGES);
    chk("drain_empty", out_valid, 1'b0);

    // Bubbles: in_valid every other cycle with the sink stalled.
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 20 && acc < STAGES; i++) begin
      if (i % 2 == 0) drive(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      else in_valid = 1'b0;
      if (in_valid && in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    chk("bubble_fill", acc, STAGES);
    chk("bubble_full_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    repeat (STAGES + 2) tick();

    // Reset with two ops in flight.
    drive(16'h1111, 16'h2222, 1'b0);
    tick();
    drive(16'h3333, 16'h4444, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_out", {out_valid, cout, sum}, 18'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rst_no_stale", out_valid, 1'b0);
    end

`ifdef PIPE_ADDER_OVF_EN
    drive(16'h7FFF, 16'h0001, 1'b0);
    tick();
    drive(16'h8000, 16'hFFFF, 1'b0);
    tick();
    drive(16'h0001, 16'hFFFF, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("ovf_pos", {out_valid, ovf, cout, sum}, 19'h6_8000);
    tick();
    chk("ovf_neg", {out_valid, ovf, cout, sum}, 19'h7_7FFF);
    tick();
    chk("ovf_none", {out_valid, ovf, cout, sum}, 19'h5_0000);
    tick();
`endif

    // Random traffic on both handshakes.
    acc = 0;
    cycles = 0;
    while (acc < N_RANDOM && cycles < 60000) begin
      if ($urandom_range(0, 3) != 0) drive(rnd_operand(), rnd_operand(), 1'($urandom));
      else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) acc++;
      tick();
      cycles++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("random_accepted", acc, N_RANDOM);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 50) begin
      tick();
      cycles++;
    end
    chk("random_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
